mux_skid_stage: RTL and testbench
=================================

# mux_skid_stage

Parametrised N-way operand selector fused with a 2-entry valid/ready skid register, used between pipeline stages where a forwarding or writeback select must be registered without losing back-pressure throughput. Each accepted transfer selects one of `NUM_IN` `WIDTH`-bit sources by `sel`, tags it with the source index and an out-of-range flag, and presents it downstream with 1-cycle latency. It sustains 1 transfer/cycle and has a synchronous flush for pipeline squash.

## Interface
- `WIDTH`, 32, data width per source
- `NUM_IN`, 3, number of sources, 2..16
- `SEL_W`, `$clog2(NUM_IN)`, select width
---
- `clk` input 1: sole clock, rising edge
- `reset` input 1: synchronous, active-high
- `in_valid` input 1: upstream has a transfer
- `in_ready` output 1: stage can accept; registered
- `sel` input `SEL_W`: source index, sampled on accept
- `data_in` input `NUM_IN*WIDTH`: flattened sources; source i at `[i*WIDTH +: WIDTH]`
- `flush` input 1: discard all held and incoming transfers
- `out_valid` output 1: `data_out` holds a transfer
- `out_ready` input 1: downstream takes the transfer
- `data_out` output `WIDTH`: selected data
- `out_src` output `SEL_W`: source index actually used
- `out_err` output 1: `sel` was ≥ `NUM_IN` for this transfer

## Operation
- Accept: `in_valid && in_ready` at a rising edge. Emit: `out_valid && out_ready` at a rising edge.
- Select: if `sel < NUM_IN`, the stage takes source `sel`, `out_src = sel`, and `out_err = 0`. Otherwise it takes source 0, `out_src = 0`, and `out_err = 1`. `{data, src, err}` travel together as one entry.
- Storage is a main register, which drives the outputs, and a skid register.
- The state machine is EMPTY / ONE / FULL, held as main_v and skid_v.
  - EMPTY: accept → ONE.
  - ONE, accept with emit → ONE. The main register is replaced by the new entry.
  - ONE, accept without emit → FULL. The new entry goes to the skid register.
  - ONE, emit without accept → EMPTY.
  - FULL: emit → ONE, with skid moved to main. There is no accept in FULL.
- `in_ready` = !skid_v (registered). It is 1 in EMPTY/ONE and 0 in FULL.
- Order is strictly preserved and no entry is dropped or duplicated except by flush.
- Flush takes priority over every transition. At the edge where `flush` = 1, main_v and skid_v clear.
  - An accept in the same cycle is discarded.
  - An emit in the same cycle still counts as taken downstream.
- `data_out`/`out_src`/`out_err` are stable while `out_valid && !out_ready`.

## Timing
- Reset: `out_valid` = 0, `data_out` = 0, `out_src` = 0, `out_err` = 0, and internal valids = 0. `in_ready` = 1 from the first cycle after reset deasserts; it reads 1 during reset as well.
- Reset mid-operation: all held entries are lost at the reset edge, with the same values as above.
- Latency: an entry accepted at edge k is visible on `out_valid`/`data_out` after edge k. It can be emitted at edge k+1 at the earliest.
- Throughput: 1 entry/cycle while `out_ready` = 1.
- `in_ready` drops in the cycle after the edge that fills the skid register. It rises in the cycle after the edge that empties it.
- After flush at edge k: `out_valid` = 0 and `in_ready` = 1 after edge k.
- Outputs are registered only. There is no combinational path from `out_ready` to `in_ready`.

## Structure
- Package `mux_skid_pkg`:
  - state encoding (`ST_EMPTY`, `ST_ONE`, `ST_FULL`) as localparams
  - entry width helper, `WIDTH + SEL_W + 1`
- Sub-module `mux_n`: combinational `NUM_IN`-way, `WIDTH`-bit selector with out-of-range→source 0 and an err output. It is reusable as the generic replacement for fixed-width muxes elsewhere in the datapath.
- The top holds the two entry registers, the valids and the `in_ready` register.

## Test plan
- Reset then single transfer, `NUM_IN` = 3.
  - Stimulus: sources 0x11111111/0x22222222/0x33333333, `sel` = 2, `out_ready` = 1.
  - Required: `out_valid` = 1 one cycle after accept, `data_out` = 0x33333333, `out_src` = 2, `out_err` = 0.
- Out-of-range select, `NUM_IN` = 3.
  - Stimulus: `sel` = 3.
  - Required: `data_out` = 0x11111111, `out_src` = 0, `out_err` = 1.
- Back-pressure.
  - Stimulus: stream of 4 entries, `sel` = 0,1,2,0, with `out_ready` = 0 for cycles 1–3.
  - Required: FULL is reached and `in_ready` = 0 after the 2nd accept. The order emitted after `out_ready` = 1 is exactly A,B,C,A with no gaps.
- Full-rate streaming.
  - Stimulus: `in_valid` and `out_ready` both held at 1 for 16 cycles.
  - Required: 16 emits, `in_ready` stays 1, each source index is matched.
- Flush.
  - Stimulus: assert `flush` in FULL together with `in_valid` = 1.
  - Required: next cycle `out_valid` = 0, `in_ready` = 1, and no flushed entry appears later.
- Reset mid-stream.
  - Stimulus: assert `reset` in FULL.
  - Required: all outputs return to their reset values next cycle; later traffic starts from EMPTY.

Source files
------------

// File: rtl/mux_skid_stage_pkg.sv
// Shared definitions for the selector + skid stage: occupancy state encoding
// and the width of one stored entry {data, src, err}.
package mux_skid_pkg;

    // Occupancy of the two entry registers (main, skid)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Bits in one stored entry: data, source index and out-of-range flag
    function automatic int entry_w(input int width, input int sel_w);
        return width + sel_w + 1;
    endfunction

endpackage

// File: rtl/mux_skid_stage_if.sv
// Handshake bundle between upstream, the selector stage and downstream.
// master = the side driving transfers in and consuming them out; slave = the stage.
interface mux_skid_stage_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = $clog2(NUM_IN)
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] data_in;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        data_out;
    logic [SEL_W-1:0]        out_src;
    logic                    out_err;

    modport slave (
        input  in_valid, sel, data_in, flush, out_ready,
        output in_ready, out_valid, data_out, out_src, out_err
    );

    modport master (
        output in_valid, sel, data_in, flush, out_ready,
        input  in_ready, out_valid, data_out, out_src, out_err
    );
endinterface

// File: rtl/mux_skid_stage_mux_n.sv
// Generic NUM_IN-way WIDTH-bit selector. An out-of-range select falls back to
// source 0 and raises err so the consumer can see the substitution.
module mux_n
    import mux_skid_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]        data,
    output logic [SEL_W-1:0]        src,
    output logic                    err
);

    // Pick the matching source; no match leaves the source-0 fallback in place
    always_comb begin
        data = data_in[WIDTH-1:0];
        src  = {SEL_W{1'b0}};
        err  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                data = data_in[i*WIDTH +: WIDTH];
                src  = SEL_W'(i);
                err  = 1'b0;
            end else begin
                data = data;
                src  = src;
                err  = err;
            end
        end
    end

endmodule

// File: rtl/mux_skid_stage.sv
// Operand selector fused with a 2-entry valid/ready skid register.
// Main register drives the outputs; the skid register absorbs the one extra
// entry accepted while downstream stalls, so in_ready never depends on
// out_ready combinationally.
module mux_skid_stage
    import mux_skid_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input logic               clk,
    input logic               reset,
    mux_skid_stage_if.slave   bus
);

    localparam int EW = entry_w(WIDTH, SEL_W);

    logic [WIDTH-1:0] mux_data_s;
    logic [SEL_W-1:0] mux_src_s;
    logic             mux_err_s;
    logic [EW-1:0]    new_entry_s;

    logic [EW-1:0]    main_r, main_n_s;
    logic [EW-1:0]    skid_r, skid_n_s;
    logic             main_v_r, main_v_n_s;
    logic             skid_v_r, skid_v_n_s;
    logic             in_ready_r;
    logic             accept_s;
    logic             emit_s;
    state_t           state_s;

    mux_n #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .sel     (bus.sel),
        .data_in (bus.data_in),
        .data    (mux_data_s),
        .src     (mux_src_s),
        .err     (mux_err_s)
    );

    assign new_entry_s = {mux_data_s, mux_src_s, mux_err_s};
    assign accept_s    = bus.in_valid && in_ready_r;
    assign emit_s      = main_v_r && bus.out_ready;

    // Decode occupancy from the two valid bits
    always_comb begin
        state_s = ST_EMPTY;
        if (skid_v_r) begin
            state_s = ST_FULL;
        end else if (main_v_r) begin
            state_s = ST_ONE;
        end else begin
            state_s = ST_EMPTY;
        end
    end

    // Next-state and entry movement; flush overrides every transition
    always_comb begin
        main_v_n_s = main_v_r;
        skid_v_n_s = skid_v_r;
        main_n_s   = main_r;
        skid_n_s   = skid_r;
        if (bus.flush) begin
            main_v_n_s = 1'b0;
            skid_v_n_s = 1'b0;
        end else begin
            case (state_s)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_n_s   = new_entry_s;
                        main_v_n_s = 1'b1;
                    end else begin
                        main_v_n_s = 1'b0;
                    end
                end
                ST_ONE: begin
                    if (accept_s && emit_s) begin
                        main_n_s = new_entry_s;
                    end else if (accept_s) begin
                        skid_n_s   = new_entry_s;
                        skid_v_n_s = 1'b1;
                    end else if (emit_s) begin
                        main_v_n_s = 1'b0;
                    end else begin
                        main_v_n_s = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (emit_s) begin
                        main_n_s   = skid_r;
                        skid_v_n_s = 1'b0;
                    end else begin
                        skid_v_n_s = 1'b1;
                    end
                end
                default: begin
                    main_v_n_s = 1'b0;
                    skid_v_n_s = 1'b0;
                end
            endcase
        end
    end

    // Entry registers, valids and the registered ready
    always_ff @(posedge clk) begin
        if (reset) begin
            main_r     <= {EW{1'b0}};
            skid_r     <= {EW{1'b0}};
            main_v_r   <= 1'b0;
            skid_v_r   <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            main_r     <= main_n_s;
            skid_r     <= skid_n_s;
            main_v_r   <= main_v_n_s;
            skid_v_r   <= skid_v_n_s;
            in_ready_r <= ~skid_v_n_s;
        end
    end

    // in_ready also reads 1 while reset is held, before the first clock edge
    assign bus.in_ready  = in_ready_r | reset;
    assign bus.out_valid = main_v_r;
    assign {bus.data_out, bus.out_src, bus.out_err} = main_r;

endmodule

// File: tb/tb_mux_skid_stage.sv
// Directed bench for mux_skid_stage with a queue scoreboard: the driver pushes
// the hand-computed entry when a transfer is accepted, the monitor pops and
// compares on every emit.
module tb_mux_skid_stage;

    localparam int W   = 32;
    localparam int N   = 3;
    localparam int SW  = 2;
    localparam int EW  = W + SW + 1;
    localparam logic [95:0] SRC = {32'h33333333, 32'h22222222, 32'h11111111};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   emit_cnt = 0;
    logic [EW-1:0] exp_q[$];

    mux_skid_stage_if #(.WIDTH(W), .NUM_IN(N)) bus ();

    mux_skid_stage #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One cycle of stimulus; pushes the expected entry if it is accepted
    task automatic cyc(input logic v, input logic [1:0] s, input logic [95:0] din,
                       input logic [31:0] ed, input logic [1:0] es, input logic ee,
                       input logic ordy, input logic fl, output logic acc);
        @(negedge clk);
        bus.in_valid  = v;
        bus.sel       = s;
        bus.data_in   = din;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        acc = v && bus.in_ready && !fl && !reset;
        if (acc) exp_q.push_back({ed, es, ee});
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: inputs are stable from negedge+1 until the next posedge
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    emit_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_emit: got %h expected no transfer",
                                 {bus.data_out, bus.out_src, bus.out_err});
                    end else begin
                        e = exp_q.pop_front();
                        chk("emit_entry", 64'({bus.data_out, bus.out_src, bus.out_err}), 64'(e));
                    end
                end
                if (bus.flush) exp_q.delete();
            end
        end
    end

    initial begin
        logic acc;
        int base;
        int n_acc;
        logic rdy_drop;
        logic [1:0] s;
        logic [31:0] ed;
        logic [1:0] es;
        logic ee;
        logic [95:0] din;

        bus.in_valid = 1'b0; bus.sel = 2'd0; bus.data_in = SRC;
        bus.out_ready = 1'b0; bus.flush = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data_out",  64'(bus.data_out), 64'd0);
        chk("rst_out_src",   64'(bus.out_src), 64'd0);
        chk("rst_out_err",   64'(bus.out_err), 64'd0);
        @(negedge clk); reset = 1'b0;
        post_edge();
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single transfer, sel=2, then out-of-range sel=3 back to back
        cyc(1'b1, 2'd2, SRC, 32'h33333333, 2'd2, 1'b0, 1'b1, 1'b0, acc);
        post_edge();
        chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_data_out",  64'(bus.data_out), 64'h33333333);
        chk("t1_out_src",   64'(bus.out_src), 64'd2);
        chk("t1_out_err",   64'(bus.out_err), 64'd0);
        cyc(1'b1, 2'd3, SRC, 32'h11111111, 2'd0, 1'b1, 1'b1, 1'b0, acc);
        post_edge();
        chk("oor_data_out", 64'(bus.data_out), 64'h11111111);
        chk("oor_out_src",  64'(bus.out_src), 64'd0);
        chk("oor_out_err",  64'(bus.out_err), 64'd1);
        cyc(1'b0, 2'd0, SRC, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, acc);

        // Back-pressure: A,B fill the stage, C is refused, then drain A,B,C,A
        cyc(1'b1, 2'd0, SRC, 32'h11111111, 2'd0, 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b1, 2'd1, SRC, 32'h22222222, 2'd1, 1'b0, 1'b0, 1'b0, acc);
        post_edge();
        chk("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_full_data_hold", 64'(bus.data_out), 64'h11111111);
        cyc(1'b1, 2'd2, SRC, 32'h33333333, 2'd2, 1'b0, 1'b0, 1'b0, acc);
        chk("bp_c_refused", 64'(acc), 64'd0);
        chk("bp_hold_stable", 64'({bus.data_out, bus.out_src, bus.out_err}),
            64'({32'h11111111, 2'd0, 1'b0}));
        base = emit_cnt;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            if (n_acc == 0) begin
                cyc(1'b1, 2'd2, SRC, 32'h33333333, 2'd2, 1'b0, 1'b1, 1'b0, acc);
            end else if (n_acc == 1) begin
                cyc(1'b1, 2'd0, SRC, 32'h11111111, 2'd0, 1'b0, 1'b1, 1'b0, acc);
            end else begin
                cyc(1'b0, 2'd0, SRC, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, acc);
                acc = 1'b0;
            end
            if (acc) n_acc++;
        end
        #2;
        chk("bp_no_gap_emits", 64'(emit_cnt - base), 64'd4);
        chk("bp_late_accepts", 64'(n_acc), 64'd2);

        // Full-rate streaming for 16 cycles with changing sources
        base = emit_cnt;
        n_acc = 0;
        rdy_drop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s   = 2'(i);
            din = {32'hC0000000 + 32'(i), 32'hB0000000 + 32'(i), 32'hA0000000 + 32'(i)};
            ed  = (s == 2'd1) ? 32'hB0000000 + 32'(i) :
                  (s == 2'd2) ? 32'hC0000000 + 32'(i) : 32'hA0000000 + 32'(i);
            es  = (s == 2'd3) ? 2'd0 : s;
            ee  = (s == 2'd3);
            cyc(1'b1, s, din, ed, es, ee, 1'b1, 1'b0, acc);
            if (acc) n_acc++;
            if (!bus.in_ready) rdy_drop = 1'b1;
        end
        cyc(1'b0, 2'd0, SRC, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, acc);
        #2;
        chk("stream_accepts", 64'(n_acc), 64'd16);
        chk("stream_in_ready_held", 64'(rdy_drop), 64'd0);
        chk("stream_emits", 64'(emit_cnt - base), 64'd16);

        // Flush in FULL with an incoming transfer
        cyc(1'b1, 2'd0, SRC, 32'h11111111, 2'd0, 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b1, 2'd1, SRC, 32'h22222222, 2'd1, 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b1, 2'd2, SRC, 32'h33333333, 2'd2, 1'b0, 1'b0, 1'b1, acc);
        post_edge();
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready",  64'(bus.in_ready), 64'd1);
        cyc(1'b1, 2'd1, SRC, 32'h22222222, 2'd1, 1'b0, 1'b1, 1'b0, acc);
        cyc(1'b0, 2'd0, SRC, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, acc);
        // Flush in ONE with accept and emit: emit counts, accept is dropped
        cyc(1'b1, 2'd0, SRC, 32'h11111111, 2'd0, 1'b0, 1'b0, 1'b0, acc);
        base = emit_cnt;
        cyc(1'b1, 2'd2, SRC, 32'h33333333, 2'd2, 1'b0, 1'b1, 1'b1, acc);
        post_edge();
        chk("flush1_out_valid", 64'(bus.out_valid), 64'd0);
        cyc(1'b0, 2'd0, SRC, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, acc);
        #2;
        chk("flush1_emit_taken", 64'(emit_cnt - base), 64'd1);

        // Reset in FULL
        cyc(1'b1, 2'd2, SRC, 32'h33333333, 2'd2, 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b1, 2'd1, SRC, 32'h22222222, 2'd1, 1'b0, 1'b0, 1'b0, acc);
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        post_edge();
        chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_data_out",  64'(bus.data_out), 64'd0);
        chk("mrst_out_src",   64'(bus.out_src), 64'd0);
        chk("mrst_out_err",   64'(bus.out_err), 64'd0);
        chk("mrst_in_ready",  64'(bus.in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        post_edge();
        chk("mrst_empty_after", 64'(bus.out_valid), 64'd0);
        cyc(1'b1, 2'd1, SRC, 32'h22222222, 2'd1, 1'b0, 1'b1, 1'b0, acc);
        post_edge();
        chk("mrst_new_data", 64'(bus.data_out), 64'h22222222);

        // Drain with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            cyc(1'b0, 2'd0, SRC, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, acc);
        end
        cyc(1'b0, 2'd0, SRC, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, acc);
        #3;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
